// File: rtl/gray_pkg.sv
// Shared definitions for gray-coded pointer handling: receiver FSM states and
// width-independent gray decode / single-bit-change helpers.
package gray_pkg;

    // Helpers work on a fixed wide vector; zero-extending a narrower gray word
    // leaves its decode unchanged, so any pointer up to this width can use them.
    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

    function automatic logic is_one_hot(input logic [GRAY_MAX_W-1:0] vec);
        return (vec != '0) && ((vec & (vec - GRAY_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a gray-coded word; reusable on any pointer path
// crossing into this clock. Depth is never allowed below two flops.
module gray_sync #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [DEPTH-1:0][W-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[DEPTH-2:0], d};
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/gray_to_bin.sv
// Combinational gray-to-binary decoder: each binary bit is the parity of the
// gray bits at and above it.
module gray_to_bin #(
    parameter int W = 8
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end

endmodule

// File: rtl/gray_ptr_receiver.sv
// Receive-side tracker for a gray-coded pointer: synchronises and decodes it,
// checks every change is a single +1 step, and hands accumulated advances downstream.
module gray_ptr_receiver
    import gray_pkg::*;
#(
    parameter int BW_DATA     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [BW_DATA-1:0] i_gray,
    input  logic               i_en,
    input  logic               i_ready,
    output logic [BW_DATA-1:0] o_bin,
    output logic [BW_DATA-1:0] o_delta,
    output logic               o_valid,
    output logic               o_err
);

    logic [BW_DATA-1:0] g_cur;
    logic [BW_DATA-1:0] g_prev;
    logic [BW_DATA-1:0] bin_cur;
    logic [BW_DATA-1:0] bin_prev;
    logic [BW_DATA-1:0] bin_prev_inc;
    logic [BW_DATA-1:0] acc;
    logic [BW_DATA-1:0] acc_nx;
    state_t             state;
    state_t             state_nx;
    logic               step;
    logic               legal;
    logic               legal_step;
    logic               valid;
    logic               transfer;

    gray_sync #(
        .W      (BW_DATA),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .d     (i_gray),
        .q     (g_cur)
    );

    gray_to_bin #(
        .W (BW_DATA)
    ) u_decode (
        .gray (g_cur),
        .bin  (bin_cur)
    );

    assign bin_prev     = BW_DATA'(gray2bin(GRAY_MAX_W'(g_prev)));
    assign bin_prev_inc = bin_prev + BW_DATA'(1);

    // A legal change flips exactly one gray bit and advances the decode by one,
    // which naturally accepts the all-ones to zero wrap.
    assign step       = (g_cur != g_prev);
    assign legal      = is_one_hot(GRAY_MAX_W'(g_cur ^ g_prev)) && (bin_cur == bin_prev_inc);
    assign legal_step = step && legal;

    assign valid    = (state == ST_TRACK) && (acc != '0);
    assign transfer = valid && i_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            g_prev <= '0;
            o_bin  <= '0;
            acc    <= '0;
            state  <= ST_IDLE;
        end else begin
            g_prev <= g_cur;
            o_bin  <= bin_cur;
            acc    <= acc_nx;
            state  <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        case (state)
            ST_IDLE: begin
                acc_nx = '0;
                if (i_en) begin
                    state_nx = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (!i_en) begin
                    state_nx = ST_IDLE;
                    acc_nx   = '0;
                end else if (step && !legal) begin
                    state_nx = ST_ERR;
                    acc_nx   = '0;
                end else if (transfer) begin
                    // The step landing on a transfer cycle starts the next count.
                    acc_nx = legal_step ? BW_DATA'(1) : '0;
                end else if (legal_step) begin
                    if (acc == '1) begin
                        state_nx = ST_ERR;
                        acc_nx   = '0;
                    end else begin
                        acc_nx = acc + BW_DATA'(1);
                    end
                end
            end
            ST_ERR: begin
                acc_nx = '0;
                if (!i_en) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                acc_nx   = '0;
            end
        endcase
    end

    assign o_delta = acc;
    assign o_valid = valid;
    assign o_err   = (state == ST_ERR);

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Self-checking bench for gray_ptr_receiver: directed scenarios plus random
// pointer traffic compared against a pointer-level reference model.
module tb_gray_ptr_receiver;

    localparam int BW      = 8;
    localparam int M_IDLE  = 0;
    localparam int M_TRACK = 1;
    localparam int M_ERR   = 2;

    logic          i_clk = 1'b0;
    logic          i_rstn;
    logic [BW-1:0] i_gray;
    logic          i_en;
    logic          i_ready;
    logic [BW-1:0] o_bin;
    logic [BW-1:0] o_delta;
    logic          o_valid;
    logic          o_err;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] hist[$];
    int            beat_log[$];
    int            m_mode;
    int            m_acc;
    int            m_adv;
    int            m_bin;
    int            dut_sum;
    int            ptr;

    always #5 i_clk = ~i_clk;

    gray_ptr_receiver #(
        .BW_DATA     (BW),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_gray  (i_gray),
        .i_en    (i_en),
        .i_ready (i_ready),
        .o_bin   (o_bin),
        .o_delta (o_delta),
        .o_valid (o_valid),
        .o_err   (o_err)
    );

    function automatic logic [BW-1:0] b2g(input int p);
        return 8'(p ^ (p >> 1));
    endfunction

    function automatic int g2b(input int g);
        int b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        return b & 255;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        repeat (4) hist.push_back('0);
        m_mode  = M_IDLE;
        m_acc   = 0;
        m_adv   = 0;
        m_bin   = 0;
        dut_sum = 0;
    endtask

    // The receiver sees the source word two edges late; decisions compare that
    // word with the one before it, counting advances in pointer arithmetic.
    task automatic model_edge(input logic [BW-1:0] g, input logic en, input logic rdy);
        int cur, prev, adv, inc;
        bit ok, take;
        hist.push_back(g);
        if (hist.size() > 8) void'(hist.pop_front());
        cur  = int'(hist[hist.size()-3]);
        prev = int'(hist[hist.size()-4]);
        inc  = (cur != prev) ? 1 : 0;
        adv  = (g2b(cur) - g2b(prev)) & 255;
        ok   = (inc == 0) || (adv == 1 && $countones(cur ^ prev) == 1);
        take = (m_mode == M_TRACK) && (m_acc != 0) && rdy;
        case (m_mode)
            M_IDLE: if (en) m_mode = M_TRACK;
            M_TRACK: begin
                if (!en) m_mode = M_IDLE;
                else if (!ok) m_mode = M_ERR;
                else begin
                    m_adv += inc;
                    if (take) m_acc = inc;
                    else if (m_acc + inc > 255) m_mode = M_ERR;
                    else m_acc += inc;
                end
            end
            default: if (!en) m_mode = M_IDLE;
        endcase
        if (m_mode != M_TRACK) begin
            m_acc = 0;
            m_adv = 0;
        end
        m_bin = g2b(cur);
    endtask

    task automatic compare_all(input string phase);
        check_output({phase, "/o_bin"},   32'(o_bin),   m_bin);
        check_output({phase, "/o_delta"}, 32'(o_delta), m_acc);
        check_output({phase, "/o_valid"}, 32'(o_valid), (m_mode == M_TRACK && m_acc != 0) ? 1 : 0);
        check_output({phase, "/o_err"},   32'(o_err),   (m_mode == M_ERR) ? 1 : 0);
        if (m_mode == M_TRACK)
            check_output({phase, "/conserve"}, dut_sum + int'(o_delta), m_adv);
    endtask

    task automatic apply_stimulus(input logic [BW-1:0] g, input logic en, input logic rdy, input string phase);
        i_gray  = g;
        i_en    = en;
        i_ready = rdy;
        if (o_valid === 1'b1 && rdy) begin
            dut_sum += int'(o_delta);
            beat_log.push_back(int'(o_delta));
        end
        @(posedge i_clk);
        model_edge(g, en, rdy);
        if (m_mode != M_TRACK) dut_sum = 0;
        @(negedge i_clk);
        compare_all(phase);
    endtask

    task automatic step_ptr(input logic en, input logic rdy, input string phase);
        ptr = (ptr + 1) & 255;
        apply_stimulus(b2g(ptr), en, rdy, phase);
    endtask

    task automatic hold(input int n, input logic en, input logic rdy, input string phase);
        repeat (n) apply_stimulus(b2g(ptr), en, rdy, phase);
    endtask

    task automatic settle_idle(input int p, input string phase);
        ptr = p;
        hold(5, 1'b0, 1'b1, phase);
    endtask

    initial begin
        int r;
        logic en, rdy;
        logic [BW-1:0] g;

        i_rstn  = 1'b0;
        i_en    = 1'b0;
        i_ready = 1'b0;
        i_gray  = '0;
        ptr     = 0;
        model_reset();
        #7;
        compare_all("reset");
        @(negedge i_clk);
        i_rstn = 1'b1;

        // Simple counting with the sink always ready.
        beat_log.delete();
        apply_stimulus(b2g(0), 1'b1, 1'b1, "t1");
        for (int p = 1; p <= 9; p++) step_ptr(1'b1, 1'b1, "t1");
        hold(5, 1'b1, 1'b1, "t1");
        check_output("t1/beats", beat_log.size(), 9);
        check_output("t1/bin", 32'(o_bin), 9);
        foreach (beat_log[i]) check_output("t1/beat_val", beat_log[i], 1);

        // Back-pressure builds a count of five; a step lands on the transfer cycle.
        settle_idle(0, "t2");
        apply_stimulus(b2g(0), 1'b1, 1'b0, "t2");
        for (int p = 1; p <= 5; p++) step_ptr(1'b1, 1'b0, "t2");
        hold(4, 1'b1, 1'b0, "t2");
        check_output("t2/delta5", 32'(o_delta), 5);
        step_ptr(1'b1, 1'b0, "t2");
        step_ptr(1'b1, 1'b0, "t2");
        beat_log.delete();
        step_ptr(1'b1, 1'b1, "t2");
        hold(5, 1'b1, 1'b1, "t2");
        check_output("t2/beats", beat_log.size(), 4);
        if (beat_log.size() >= 2) begin
            check_output("t2/first_beat", beat_log[0], 5);
            check_output("t2/second_beat", beat_log[1], 1);
        end

        // Wrap from 255 back to 0.
        settle_idle(254, "t3");
        apply_stimulus(b2g(254), 1'b1, 1'b1, "t3");
        beat_log.delete();
        for (int k = 0; k < 3; k++) step_ptr(1'b1, 1'b1, "t3");
        hold(5, 1'b1, 1'b1, "t3");
        check_output("t3/beats", beat_log.size(), 3);
        check_output("t3/bin", 32'(o_bin), 1);
        check_output("t3/err", 32'(o_err), 0);

        // Two-bit jump is flagged and held until tracking is dropped.
        settle_idle(0, "t4");
        apply_stimulus(b2g(0), 1'b1, 1'b1, "t4");
        hold(2, 1'b1, 1'b1, "t4");
        apply_stimulus(8'h03, 1'b1, 1'b1, "t4");
        ptr = 2;
        hold(6, 1'b1, 1'b1, "t4");
        check_output("t4/err_set", 32'(o_err), 1);
        check_output("t4/valid_off", 32'(o_valid), 0);
        hold(1, 1'b0, 1'b1, "t4");
        check_output("t4/err_clr", 32'(o_err), 0);
        hold(3, 1'b1, 1'b1, "t4");
        step_ptr(1'b1, 1'b1, "t4");
        step_ptr(1'b1, 1'b1, "t4");
        hold(5, 1'b1, 1'b1, "t4");
        check_output("t4/resume_err", 32'(o_err), 0);
        check_output("t4/resume_bin", 32'(o_bin), 4);

        // Accumulator saturates at 255; one more step is an overflow.
        settle_idle(0, "t5");
        apply_stimulus(b2g(0), 1'b1, 1'b0, "t5");
        for (int k = 0; k < 255; k++) step_ptr(1'b1, 1'b0, "t5");
        hold(4, 1'b1, 1'b0, "t5");
        check_output("t5/delta255", 32'(o_delta), 255);
        step_ptr(1'b1, 1'b0, "t5");
        hold(4, 1'b1, 1'b0, "t5");
        check_output("t5/overflow_err", 32'(o_err), 1);

        // Asynchronous reset between clock edges.
        settle_idle(0, "t6");
        apply_stimulus(b2g(0), 1'b1, 1'b0, "t6");
        for (int k = 0; k < 3; k++) step_ptr(1'b1, 1'b0, "t6");
        hold(4, 1'b1, 1'b0, "t6");
        check_output("t6/pre_delta", 32'(o_delta), 3);
        #1 i_rstn = 1'b0;
        #1;
        check_output("t6/rst_bin",   32'(o_bin),   0);
        check_output("t6/rst_delta", 32'(o_delta), 0);
        check_output("t6/rst_valid", 32'(o_valid), 0);
        check_output("t6/rst_err",   32'(o_err),   0);
        model_reset();
        #1 i_rstn = 1'b1;
        hold(5, 1'b0, 1'b1, "t6");
        hold(2, 1'b1, 1'b1, "t6");
        step_ptr(1'b1, 1'b1, "t6");
        hold(5, 1'b1, 1'b1, "t6");
        check_output("t6/resume_bin", 32'(o_bin), 4);

        // Random traffic with back-pressure, idle gaps and occasional corruption.
        for (int n = 0; n < 1500; n++) begin
            en  = ($urandom_range(0, 49) != 0);
            if (m_mode == M_ERR && $urandom_range(0, 3) == 0) en = 1'b0;
            rdy = 1'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 99));
            if (r < 2) begin
                g   = 8'($urandom);
                ptr = g2b(int'(g));
            end else if (r < 50) begin
                ptr = (ptr + 1) & 255;
                g   = b2g(ptr);
            end else begin
                g = b2g(ptr);
            end
            apply_stimulus(g, en, rdy, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
